// File: rtl/scs8hd_bist_pkg.sv
// Shared types and golden model for the a32oi cell BIST controllers.
package scs8hd_bist_pkg;

   localparam int VEC_W   = 5;
   localparam int NUM_VEC = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Y = ~((A1&A2&A3)|(B1&B2)) with {A1,A2,A3,B1,B2} = v[4:0]
   function automatic logic a32oi_exp(input logic [VEC_W-1:0] v);
      return ~((v[4] & v[3] & v[2]) | (v[1] & v[0]));
   endfunction

endpackage

// File: rtl/scs8hd_bist_settle_cnt.sv
// Loadable down-counter with zero flag, shared by the cell BIST sequencers.
module scs8hd_bist_settle_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   assign zero = (count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !zero) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/scs8hd_a32oi_bist_ctrl.sv
// Exhaustive 32-vector BIST sequencer for one a32oi cell instance.
module scs8hd_a32oi_bist_ctrl
   import scs8hd_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             RESETB,
   input  logic             start,
   input  logic             abort,
   input  logic             dut_y,
   output logic [VEC_W-1:0] dut_vec,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [5:0]       fail_cnt,
   output logic [VEC_W-1:0] first_fail_vec,
   output logic             first_fail_vld,
   output logic             aborted
);

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);
   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

   state_t           state;
   logic [VEC_W-1:0] vec;
   logic             cnt_zero;
   logic             miss;
   logic             run_abort;

   assign dut_vec   = vec;
   assign miss      = (dut_y != a32oi_exp(vec));
   assign run_abort = abort && (state == SETTLE || state == SAMPLE);

   // Reloaded outside SETTLE so every settle window starts full.
   scs8hd_bist_settle_cnt #(.W(4)) u_settle (
      .clk      (CLK),
      .rst_n    (RESETB),
      .load     (state != SETTLE),
      .dec      (state == SETTLE),
      .load_val (SETTLE_LD),
      .zero     (cnt_zero)
   );

   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         state          <= IDLE;
         vec            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_cnt       <= '0;
         first_fail_vec <= '0;
         first_fail_vld <= 1'b0;
         aborted        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (run_abort) begin
            state   <= IDLE;
            vec     <= '0;
            busy    <= 1'b0;
            aborted <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && !abort) begin
                     state          <= SETTLE;
                     vec            <= '0;
                     busy           <= 1'b1;
                     pass           <= 1'b0;
                     fail_cnt       <= '0;
                     first_fail_vec <= '0;
                     first_fail_vld <= 1'b0;
                     aborted        <= 1'b0;
                  end
               end
               SETTLE: begin
                  if (cnt_zero) state <= SAMPLE;
               end
               SAMPLE: begin
                  if (miss) begin
                     fail_cnt <= fail_cnt + 6'd1;
                     if (!first_fail_vld) begin
                        first_fail_vec <= vec;
                        first_fail_vld <= 1'b1;
                     end
                  end
                  if (vec == LAST_VEC) begin
                     state <= DONE;
                  end else begin
                     vec   <= vec + 1'b1;
                     state <= SETTLE;
                  end
               end
               DONE: begin
                  done  <= 1'b1;
                  pass  <= (fail_cnt == 6'd0);
                  busy  <= 1'b0;
                  vec   <= '0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
